// File: rtl/pipelined_cla_adder_if.sv
// Stream interface for pipelined_cla_adder.
//   Input side : in_valid/in_ready handshake carrying in_a, in_b, in_cin, in_sub.
//   Output side: out_valid/out_ready handshake carrying out_sum, out_cout, out_ovf.
//   master - the producer of operands and consumer of results (e.g. a testbench).
//   slave  - the adder itself.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// WIDTH is split into NGRP = WIDTH/GROUP lookahead groups; stage k resolves
// group k and registers its sum, its carry-out, the remaining operand bits and
// the lower sums already produced. Latency NGRP cycles, throughput 1 beat/cycle.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset; flushes every in-flight beat
//   bus  - slave side of pipelined_cla_adder_if:
//          in_valid/in_ready/in_a/in_b/in_cin/in_sub  operand stream
//          out_valid/out_ready/out_sum/out_cout/out_ovf result stream
//          in_sub=1 computes A - B - cin; out_cout=1 then means no borrow.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int unsigned NGRP = WIDTH / GROUP;

  if (GROUP == 0 || GROUP > 8 || (WIDTH % GROUP) != 0) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH=%0d must be a multiple of GROUP=%0d, GROUP in 1..8",
           WIDTH, GROUP);
  end

  logic [WIDTH-1:0] a_q   [NGRP];
  logic [WIDTH-1:0] a_d   [NGRP];
  logic [WIDTH-1:0] b_q   [NGRP];
  logic [WIDTH-1:0] b_d   [NGRP];
  logic [WIDTH-1:0] sum_q [NGRP];
  logic [WIDTH-1:0] sum_d [NGRP];
  logic [NGRP-1:0]  carry_q, carry_d;
  logic [NGRP-1:0]  valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             adv;
  logic             unused_ops;

  // Every carry of the group is expanded from g/p/cin directly, so no carry
  // depends on a neighbouring carry inside the group.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic             cin);
    logic [GROUP:0] c;
    logic           t;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < GROUP; i++) begin
      t = cin;
      for (int unsigned j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int unsigned j = 0; j <= i; j++) begin
        t = g[j];
        for (int unsigned m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  assign adv = !valid_q[NGRP-1] || bus.out_ready;

  always_comb begin
    logic [WIDTH-1:0] a_in [NGRP];
    logic [WIDTH-1:0] b_in [NGRP];
    logic [WIDTH-1:0] s_in [NGRP];
    logic [NGRP-1:0]  c_in;
    logic [GROUP-1:0] ga, gb;
    logic [GROUP:0]   gc;

    // Stage 0 takes the prepared operands; stage k takes stage k-1's registers.
    a_in[0] = bus.in_a;
    b_in[0] = bus.in_sub ? ~bus.in_b : bus.in_b;
    s_in[0] = '0;
    c_in    = '0;
    c_in[0] = bus.in_sub ? ~bus.in_cin : bus.in_cin;
    valid_d    = '0;
    valid_d[0] = bus.in_valid;
    for (int unsigned k = 1; k < NGRP; k++) begin
      a_in[k]    = a_q[k-1];
      b_in[k]    = b_q[k-1];
      s_in[k]    = sum_q[k-1];
      c_in[k]    = carry_q[k-1];
      valid_d[k] = valid_q[k-1];
    end

    carry_d = '0;
    gc      = '0;
    for (int unsigned k = 0; k < NGRP; k++) begin
      ga         = a_in[k][k*GROUP +: GROUP];
      gb         = b_in[k][k*GROUP +: GROUP];
      gc         = cla_carries(ga & gb, ga ^ gb, c_in[k]);
      a_d[k]     = a_in[k];
      b_d[k]     = b_in[k];
      sum_d[k]   = s_in[k];
      sum_d[k][k*GROUP +: GROUP] = (ga ^ gb) ^ gc[GROUP-1:0];
      carry_d[k] = gc[GROUP];
    end
    // gc still holds the last group's carries: c_WIDTH ^ c_(WIDTH-1).
    ovf_d = gc[GROUP] ^ gc[GROUP-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NGRP; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < NGRP; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
      carry_q <= carry_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Last stage's operand copies have no consumer.
  assign unused_ops = ^{a_q[NGRP-1], b_q[NGRP-1]};

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[NGRP-1];
  assign bus.out_sum   = sum_q[NGRP-1];
  assign bus.out_cout  = carry_q[NGRP-1];
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_cla_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  pipelined_cla_adder #(.WIDTH(8),  .GROUP(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] ext;
    exp_t        r;
    bb     = sub ? ~b : b;
    ext    = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? ~cin : cin)};
    r.sum  = ext[15:0];
    r.cout = ext[16];
    r.ovf  = (a[15] == bb[15]) && (ext[15] != a[15]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus16.out_valid, bus16.out_sum, bus16.out_cout, bus16.out_ovf} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_out16: got valid=%b sum=%h cout=%b ovf=%b, expected all 0",
               bus16.out_valid, bus16.out_sum, bus16.out_cout, bus16.out_ovf);
    end
    n_vec++;
    if (bus16.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready16: got %b, expected 1", bus16.in_ready);
    end
    n_vec++;
    if ({bus8.out_valid, bus8.out_sum, bus8.out_cout, bus8.out_ovf, bus8.in_ready} !== 12'b1) begin
      n_err++;
      $display("FAIL reset_dut8: got valid=%b sum=%h cout=%b ovf=%b in_ready=%b, expected 0/00/0/0/1",
               bus8.out_valid, bus8.out_sum, bus8.out_cout, bus8.out_ovf, bus8.in_ready);
    end
  endtask

  task automatic test_flags();
    logic [15:0] ta[5], tb[5], ts[5];
    logic        tci[5], tsub[5], tco[5], tov[5];
    int unsigned lat;
    exp_t        e;
    ta  = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0000};
    tb  = '{16'h0001, 16'h0001, 16'h0001, 16'h0003, 16'h0000};
    tci = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tsub= '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ts  = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'h0001};
    tco = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tov = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus16.in_a = ta[i]; bus16.in_b = tb[i];
      bus16.in_cin = tci[i]; bus16.in_sub = tsub[i];
      bus16.in_valid = 1'b1;
      sbq.push_back('{ts[i], tco[i], tov[i]});
      tick();
      bus16.in_valid = 1'b0;
      lat = 1;
      while (!bus16.out_valid && lat < 20) begin
        tick();
        lat++;
      end
      n_vec++;
      if (lat != 4) begin
        n_err++;
        $display("FAIL flags_latency[%0d]: got %0d cycles, expected 4", i, lat);
      end
      e = sbq.pop_front();
      n_vec++;
      if ({bus16.out_valid, bus16.out_sum, bus16.out_cout, bus16.out_ovf} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL flags_result[%0d]: got valid=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                 i, bus16.out_valid, bus16.out_sum, bus16.out_cout, bus16.out_ovf,
                 e.sum, e.cout, e.ovf);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n_sent = 0;
    logic        pend = 1'b0;
    logic [17:0] snap = '0;
    exp_t        e;
    for (int cyc = 0; cyc < 60 && (n_sent < 8 || pend || sbq.size() > 0); cyc++) begin
      if (!pend && n_sent < 8) begin
        bus16.in_a = 16'($urandom); bus16.in_b = 16'($urandom);
        bus16.in_cin = 1'($urandom); bus16.in_sub = 1'($urandom);
        pend = 1'b1;
      end
      bus16.in_valid  = pend;
      bus16.out_ready = (cyc >= 7);
      #1;
      if (cyc >= 4 && cyc < 7) begin
        n_vec++;
        if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_full[%0d]: got in_ready=%b out_valid=%b, expected 0 1",
                   cyc, bus16.in_ready, bus16.out_valid);
        end
        if (cyc == 4) snap = {bus16.out_sum, bus16.out_cout, bus16.out_ovf};
        else begin
          n_vec++;
          if ({bus16.out_sum, bus16.out_cout, bus16.out_ovf} !== snap) begin
            n_err++;
            $display("FAIL b2b_hold[%0d]: got %h, expected %h", cyc,
                     {bus16.out_sum, bus16.out_cout, bus16.out_ovf}, snap);
          end
        end
      end
      if (bus16.out_valid && bus16.out_ready) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra: got sum=%h with no beat outstanding, expected none", bus16.out_sum);
        end else begin
          e = sbq.pop_front();
          if ({bus16.out_sum, bus16.out_cout, bus16.out_ovf} !== e) begin
            n_err++;
            $display("FAIL b2b_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     bus16.out_sum, bus16.out_cout, bus16.out_ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (pend && bus16.in_ready) begin
        sbq.push_back(model(bus16.in_a, bus16.in_b, bus16.in_cin, bus16.in_sub));
        n_sent++;
        pend = 1'b0;
      end
      tick();
    end
    bus16.in_valid = 1'b0;
    n_vec++;
    if (n_sent != 8 || sbq.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: got sent=%0d outstanding=%0d, expected 8 0", n_sent, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_mid_reset();
    logic saw = 1'b0;
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus16.in_a = 16'($urandom); bus16.in_b = 16'($urandom);
      bus16.in_cin = 1'b0; bus16.in_sub = 1'b0;
      bus16.in_valid = 1'b1;
      tick();
    end
    bus16.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus16.out_valid, bus16.out_sum, bus16.out_cout, bus16.out_ovf} !== 19'd0) begin
      n_err++;
      $display("FAIL midrst_out: got valid=%b sum=%h cout=%b ovf=%b, expected all 0",
               bus16.out_valid, bus16.out_sum, bus16.out_cout, bus16.out_ovf);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus16.out_valid) saw = 1'b1;
    end
    n_vec++;
    if (saw !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_stale: got out_valid=1 after reset, expected 0");
    end
  endtask

  task automatic test_random();
    int unsigned n_sent = 0;
    logic        pend = 1'b0;
    exp_t        e;
    for (int cyc = 0; cyc < 40000 && (n_sent < 10000 || pend || sbq.size() > 0); cyc++) begin
      if (!pend && n_sent < 10000 && ($urandom_range(3) != 0)) begin
        bus16.in_a = 16'($urandom); bus16.in_b = 16'($urandom);
        bus16.in_cin = 1'($urandom); bus16.in_sub = 1'($urandom);
        pend = 1'b1;
      end
      bus16.in_valid  = pend;
      bus16.out_ready = ($urandom_range(3) != 0);
      #1;
      if (bus16.out_valid && bus16.out_ready) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: got sum=%h with no beat outstanding, expected none", bus16.out_sum);
        end else begin
          e = sbq.pop_front();
          if ({bus16.out_sum, bus16.out_cout, bus16.out_ovf} !== e) begin
            n_err++;
            $display("FAIL rand_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     bus16.out_sum, bus16.out_cout, bus16.out_ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (pend && bus16.in_ready) begin
        sbq.push_back(model(bus16.in_a, bus16.in_b, bus16.in_cin, bus16.in_sub));
        n_sent++;
        pend = 1'b0;
      end
      tick();
    end
    bus16.in_valid = 1'b0;
    n_vec++;
    if (n_sent != 10000 || sbq.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: got sent=%0d outstanding=%0d, expected 10000 0", n_sent, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_single_stage();
    logic [7:0]  ta[3], tb[3], ts[3];
    logic        tsub[3], tco[3], tov[3];
    int unsigned lat;
    ta   = '{8'h80, 8'h7F, 8'h00};
    tb   = '{8'h80, 8'h01, 8'h01};
    tsub = '{1'b0, 1'b0, 1'b1};
    ts   = '{8'h00, 8'h80, 8'hFF};
    tco  = '{1'b1, 1'b0, 1'b0};
    tov  = '{1'b1, 1'b1, 1'b0};
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus8.in_a = ta[i]; bus8.in_b = tb[i];
      bus8.in_cin = 1'b0; bus8.in_sub = tsub[i];
      bus8.in_valid = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
      lat = 1;
      while (!bus8.out_valid && lat < 20) begin
        tick();
        lat++;
      end
      n_vec++;
      if (lat != 1) begin
        n_err++;
        $display("FAIL single_latency[%0d]: got %0d cycles, expected 1", i, lat);
      end
      n_vec++;
      if ({bus8.out_sum, bus8.out_cout, bus8.out_ovf} !== {ts[i], tco[i], tov[i]}) begin
        n_err++;
        $display("FAIL single_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                 i, bus8.out_sum, bus8.out_cout, bus8.out_ovf, ts[i], tco[i], tov[i]);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0;
    bus16.in_cin = 1'b0; bus16.in_sub = 1'b0; bus16.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0;
    bus8.in_cin = 1'b0; bus8.in_sub = 1'b0; bus8.out_ready = 1'b0;
    #1;
    test_reset();
    test_flags();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_single_stage();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion by time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
